// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store sequencer: MemSize codes, FSM states, lane helpers.
// Optional feature macro: LSU_MISALIGN_EXC_EN (used by lsu_align / lsu_ctrl).
package lsu_ctrl_pkg;

   localparam logic [1:0] MEM_B = 2'b00;
   localparam logic [1:0] MEM_H = 2'b01;
   localparam logic [1:0] MEM_W = 2'b10;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'b00,
      LSU_REQ  = 2'b01,
      LSU_RESP = 2'b10,
      LSU_DONE = 2'b11
   } lsu_state_e;

   // Byte offset of the addressed lane; offending low bits are dropped for half/word.
   function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         MEM_B:   return addr_lo;
         MEM_H:   return {addr_lo[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         MEM_B:   return 1'b0;
         MEM_H:   return addr_lo[0];
         default: return |addr_lo;
      endcase
   endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Handshaked data-memory bus between lsu_ctrl (master) and the memory (slave).
// Optional feature macro: LSU_MISALIGN_EXC_EN (does not affect this bus).
interface lsu_ctrl_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_ctrl_align.sv
// Combinational lane logic: byte enables, store replication, load extraction/extension.
// Optional feature macro: LSU_MISALIGN_EXC_EN adds the misalignment detector output.
module lsu_align
   import lsu_ctrl_pkg::*;
(
   input  logic [1:0]  i_st_size,
   input  logic [1:0]  i_st_addr_lo,
   input  logic [31:0] i_st_data,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   input  logic [1:0]  i_ld_size,
   input  logic [1:0]  i_ld_addr_lo,
   input  logic        i_ld_sign,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_ld_data
`ifdef LSU_MISALIGN_EXC_EN
   ,
   output logic        o_misalign
`endif
);

   logic [31:0] w_lane;

   always_comb begin
      o_be    = '0;
      o_wdata = '0;
      case (i_st_size)
         MEM_B: begin
            o_be    = 4'b0001 << i_st_addr_lo;
            o_wdata = {4{i_st_data[7:0]}};
         end
         MEM_H: begin
            o_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata = {2{i_st_data[15:0]}};
         end
         default: begin
            o_be    = 4'b1111;
            o_wdata = i_st_data;
         end
      endcase
   end

   always_comb begin
      w_lane    = i_rdata >> {lane_offset(i_ld_size, i_ld_addr_lo), 3'b000};
      o_ld_data = '0;
      case (i_ld_size)
         MEM_B:   o_ld_data = {{24{i_ld_sign & w_lane[7]}},  w_lane[7:0]};
         MEM_H:   o_ld_data = {{16{i_ld_sign & w_lane[15]}}, w_lane[15:0]};
         default: o_ld_data = i_rdata;
      endcase
   end

`ifdef LSU_MISALIGN_EXC_EN
   assign o_misalign = is_misaligned(i_st_size, i_st_addr_lo);
`endif

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one memory op at a time, stalls the core until done pulses.
// Optional feature macro: LSU_MISALIGN_EXC_EN (misaligned half/word completes with misalign=1).
module lsu_ctrl
   import lsu_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   lsu_ctrl_if.master  bus,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_sign,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] load_data
`ifdef LSU_MISALIGN_EXC_EN
   ,
   output logic        misalign
`endif
);

   lsu_state_e  r_state;
   lsu_state_e  w_next;
   logic        w_accept;
   logic        w_capture;
   logic        w_stall;
   logic        w_misalign;
   logic [1:0]  w_size;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_ld_data;

   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [3:0]  r_mem_be;
   logic [31:0] r_mem_wdata;
   logic [1:0]  r_size;
   logic [1:0]  r_addr_lo;
   logic        r_sign;
   logic [31:0] r_load_data;

   assign w_size = (req_size == 2'b11) ? MEM_W : req_size;

   lsu_align u_align (
      .i_st_size    (w_size),
      .i_st_addr_lo (req_addr[1:0]),
      .i_st_data    (req_wdata),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .i_ld_size    (r_size),
      .i_ld_addr_lo (r_addr_lo),
      .i_ld_sign    (r_sign),
      .i_rdata      (bus.mem_rdata),
      .o_ld_data    (w_ld_data)
`ifdef LSU_MISALIGN_EXC_EN
      ,
      .o_misalign   (w_misalign)
`endif
   );

`ifndef LSU_MISALIGN_EXC_EN
   assign w_misalign = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= LSU_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_capture = 1'b0;
      w_stall   = 1'b0;
      case (r_state)
         LSU_IDLE: begin
            w_stall = req_valid;
            if (req_valid) begin
               w_accept = 1'b1;
               w_next   = w_misalign ? LSU_DONE : LSU_REQ;
            end
         end
         LSU_REQ: begin
            w_stall = 1'b1;
            if (bus.mem_gnt) w_next = r_mem_we ? LSU_DONE : LSU_RESP;
         end
         LSU_RESP: begin
            w_stall = 1'b1;
            if (bus.mem_rvalid) begin
               w_capture = 1'b1;
               w_next    = LSU_DONE;
            end
         end
         default: w_next = LSU_IDLE;
      endcase
   end

   // mem_req follows the next state so the request is registered yet drops right on grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_size      <= '0;
         r_addr_lo   <= '0;
         r_sign      <= 1'b0;
         r_load_data <= '0;
      end else begin
         r_mem_req <= (w_next == LSU_REQ);
         if (w_accept) begin
            r_mem_we    <= req_write;
            r_mem_addr  <= {req_addr[31:2], 2'b00};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
            r_size      <= w_size;
            r_addr_lo   <= req_addr[1:0];
            r_sign      <= req_sign;
            if (w_misalign) r_load_data <= '0;
         end
         if (w_capture) r_load_data <= w_ld_data;
      end
   end

`ifdef LSU_MISALIGN_EXC_EN
   logic r_misalign;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_misalign <= 1'b0;
      else if (w_accept) r_misalign <= w_misalign;
   end

   assign misalign = r_misalign & done;
`endif

   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_be    = r_mem_be;
   assign bus.mem_wdata = r_mem_wdata;
   assign stall         = w_stall;
   assign done          = (r_state == LSU_DONE);
   assign load_data     = r_load_data;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with hand-computed bus and load results.
// Optional feature macro: LSU_MISALIGN_EXC_EN selects the misaligned-access expectations.
module tb_lsu_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_sign;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        done;
   logic [31:0] load_data;
`ifdef LSU_MISALIGN_EXC_EN
   logic        misalign;
`endif

   int unsigned n_cmp;
   int unsigned n_err;

   lsu_ctrl_if bus ();

   lsu_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.master),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_size  (req_size),
      .req_sign  (req_sign),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .stall     (stall),
      .done      (done),
      .load_data (load_data)
`ifdef LSU_MISALIGN_EXC_EN
      ,
      .misalign  (misalign)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Cycle 0 = request presented in IDLE; returns in the cycle after DONE with req_valid low.
   task automatic run_op(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int unsigned gd, input int unsigned rd, input logic [31:0] rdat,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] exp_ld);
      chk({tag, ":idle_req"}, {31'd0, bus.mem_req}, 32'd0);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_sign = sg;
      req_addr = addr; req_wdata = wd;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      #1;
      chk({tag, ":stall0"}, {31'd0, stall}, 32'd1);
      step();
      for (int unsigned k = 0; k <= gd; k++) begin
         chk({tag, ":req"},   {31'd0, bus.mem_req}, 32'd1);
         chk({tag, ":we"},    {31'd0, bus.mem_we}, {31'd0, wr});
         chk({tag, ":addr"},  bus.mem_addr, exp_addr);
         chk({tag, ":be"},    {28'd0, bus.mem_be}, {28'd0, exp_be});
         if (wr) chk({tag, ":wdata"}, bus.mem_wdata, exp_wd);
         chk({tag, ":stallq"}, {31'd0, stall}, 32'd1);
         chk({tag, ":doneq"},  {31'd0, done}, 32'd0);
         bus.mem_gnt = (k == gd);
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata = 32'h5A5A5A5A;
         step();
      end
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (!wr) begin
         for (int unsigned k = 0; k <= rd; k++) begin
            chk({tag, ":resp_req"},   {31'd0, bus.mem_req}, 32'd0);
            chk({tag, ":resp_stall"}, {31'd0, stall}, 32'd1);
            chk({tag, ":resp_done"},  {31'd0, done}, 32'd0);
            bus.mem_rvalid = (k == rd);
            bus.mem_rdata  = (k == rd) ? rdat : ~rdat;
            step();
         end
         bus.mem_rvalid = 1'b0;
      end
      chk({tag, ":done"},       {31'd0, done}, 32'd1);
      chk({tag, ":done_stall"}, {31'd0, stall}, 32'd0);
      chk({tag, ":done_req"},   {31'd0, bus.mem_req}, 32'd0);
      if (!wr) chk({tag, ":ldata"}, load_data, exp_ld);
      req_valid = 1'b0;
      step();
      chk({tag, ":after_done"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      rst = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_sign = 1'b0;
      req_addr = '0; req_wdata = '0;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      step(); step();
      chk("rst_req",   {31'd0, bus.mem_req}, 32'd0);
      chk("rst_we",    {31'd0, bus.mem_we}, 32'd0);
      chk("rst_addr",  bus.mem_addr, 32'd0);
      chk("rst_be",    {28'd0, bus.mem_be}, 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
      chk("rst_ldata", load_data, 32'd0);
      chk("rst_done",  {31'd0, done}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      rst = 1'b0;
      step();

      run_op("sb",  1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h1234_56A5, 0, 0, 32'h0,
             32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0);
      run_op("lh",  1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 0, 0, 32'h8001_1234,
             32'h0000_2000, 4'b1100, 32'h0, 32'hFFFF_8001);
      run_op("lhu", 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 0, 0, 32'h8001_1234,
             32'h0000_2000, 4'b1100, 32'h0, 32'h0000_8001);
      run_op("sh_gnt3", 1'b1, 2'b01, 1'b0, 32'h0000_4002, 32'hABCD_1234, 3, 0, 32'h0,
             32'h0000_4000, 4'b1100, 32'h1234_1234, 32'h0);
      run_op("lb1", 1'b0, 2'b00, 1'b1, 32'h0000_5001, 32'h0, 1, 0, 32'h1234_8056,
             32'h0000_5000, 4'b0010, 32'h0, 32'hFFFF_FF80);
      run_op("lbu3", 1'b0, 2'b00, 1'b0, 32'h0000_5003, 32'h0, 0, 0, 32'hF234_8056,
             32'h0000_5000, 4'b1000, 32'h0, 32'h0000_00F2);
      run_op("lw_rv2", 1'b0, 2'b10, 1'b1, 32'h0000_6004, 32'h0, 0, 1, 32'hDEAD_BEEF,
             32'h0000_6004, 4'b1111, 32'h0, 32'hDEAD_BEEF);
      run_op("sw_b2b", 1'b1, 2'b11, 1'b0, 32'h0000_6008, 32'hCAFE_0001, 0, 0, 32'h0,
             32'h0000_6008, 4'b1111, 32'hCAFE_0001, 32'h0);

`ifdef LSU_MISALIGN_EXC_EN
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_sign = 1'b0;
      req_addr = 32'h0000_3001; bus.mem_gnt = 1'b1;
      step();
      chk("mis:req",      {31'd0, bus.mem_req}, 32'd0);
      chk("mis:done",     {31'd0, done}, 32'd1);
      chk("mis:misalign", {31'd0, misalign}, 32'd1);
      chk("mis:ldata",    load_data, 32'd0);
      req_valid = 1'b0; bus.mem_gnt = 1'b0;
      step();
      chk("mis:after",    {31'd0, misalign}, 32'd0);
`else
      run_op("lw_mis", 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 0, 0, 32'hCAFE_F00D,
             32'h0000_3000, 4'b1111, 32'h0, 32'hCAFE_F00D);
      run_op("lh_mis", 1'b0, 2'b01, 1'b1, 32'h0000_3003, 32'h0, 0, 0, 32'h7654_3210,
             32'h0000_3000, 4'b1100, 32'h0, 32'h0000_7654);
`endif

      // Reset while waiting for read data: access abandoned, late rvalid ignored.
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_sign = 1'b0;
      req_addr = 32'h0000_7000;
      step();
      bus.mem_gnt = 1'b1;
      step();
      bus.mem_gnt = 1'b0;
      chk("rr:in_resp", {31'd0, stall}, 32'd1);
      rst = 1'b1; req_valid = 1'b0;
      #1;
      chk("rr:req",   {31'd0, bus.mem_req}, 32'd0);
      chk("rr:we",    {31'd0, bus.mem_we}, 32'd0);
      chk("rr:addr",  bus.mem_addr, 32'd0);
      chk("rr:be",    {28'd0, bus.mem_be}, 32'd0);
      chk("rr:ldata", load_data, 32'd0);
      chk("rr:done",  {31'd0, done}, 32'd0);
      chk("rr:stall", {31'd0, stall}, 32'd0);
      step();
      rst = 1'b0;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_2222;
      step();
      bus.mem_rvalid = 1'b0;
      chk("rr:late_done",  {31'd0, done}, 32'd0);
      chk("rr:late_ldata", load_data, 32'd0);
      step();
      chk("rr:late_done2", {31'd0, done}, 32'd0);
      chk("rr:late_req",   {31'd0, bus.mem_req}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Multi-cycle load/store sequencer between the core's control/datapath and a handshaked data-memory bus. It accepts one memory operation at a time from the decoded instruction (MemWrite, MemSize, ExtSign, ALU address, rs2 data), and holds the core with `stall` while the access runs. It drives word-aligned bus requests with byte enables and returns a sign- or zero-extended load result to the writeback mux.

## Interface
- No parameters; widths are fixed at 32-bit address and data.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: the current instruction is a load or store.
- `req_write` in 1: 1 = store, 0 = load (MemWrite).
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 treated as word (MemSize).
- `req_sign` in 1: sign-extend the load result (ExtSign).
- `req_addr` in 32: byte address from the ALU.
- `req_wdata` in 32: store data (rs2).
- `stall` out 1: core must hold PC and register-file write.
- `done` out 1: one-cycle completion pulse.
- `load_data` out 32: extended load result; valid while `done`=1.
- `misalign` out 1: misaligned-access flag, qualified by `done`. Present only with `LSU_MISALIGN_EXC_EN`.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write enable.
- `mem_addr` out 32: word-aligned address, `{req_addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_gnt` in 1: bus accepted the request this cycle.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read data.

## Operation
FSM states: IDLE, REQ, RESP, DONE.
- **IDLE:** if `req_valid`=1, register the address, size, sign, write flag, byte enables and store data, then go to REQ.
- **REQ:** `mem_req`=1. Address, byte enables, write data and `mem_we` are held stable until `mem_gnt`. On `mem_gnt`, go to DONE for a store or to RESP for a load. `mem_rvalid` is ignored in REQ.
- **RESP:** wait for `mem_rvalid`. On `mem_rvalid`, capture the extracted and extended data into `load_data`, then go to DONE.
- **DONE:** `done`=1, then go to IDLE unconditionally. `req_valid` seen in DONE belongs to the same instruction and is not re-accepted.
- **Stall:** `stall` = (`req_valid` in IDLE) or (state is REQ or RESP). It is 0 in DONE, so the core advances on the `done` edge.
- **Byte enables:**
  - byte: `4'b0001 << addr[1:0]`
  - half: `addr[1] ? 4'b1100 : 4'b0011`
  - word: `4'b1111`
- **Store data:** byte replicated ×4; half replicated ×2; word passed through.
- **Load extract:** lane = `mem_rdata >> (8*addr[1:0])`, truncated to size. Bit 7 or bit 15 is replicated when `req_sign`=1, otherwise zero-filled. Words pass through unchanged.

## Timing
- **Reset values:** state IDLE; `mem_req`, `mem_we`, `done`, `misalign` = 0; `mem_addr`, `mem_be`, `mem_wdata`, `load_data` = 0.
- **Store latency:** with `mem_gnt` in the first REQ cycle, `done` is high in cycle 2 (request seen in cycle 0).
- **Load latency:** minimum `done` in cycle 3, with `mem_rvalid` in the cycle after `mem_gnt`. Every extra cycle of gnt or rvalid delay adds one cycle.
- **Throughput:** a new request may be accepted in the cycle after DONE.
- **Registered outputs:** all bus outputs are registered. `stall` is combinational from state and `req_valid`.
- **Reset mid-operation:** the access is abandoned, `mem_req` drops immediately, and no `done` is produced. A late `mem_rvalid` after reset is ignored in IDLE.

## Configuration
- **`LSU_MISALIGN_EXC_EN` defined:** a half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, goes IDLE→DONE with no bus access. `done`=1, `misalign`=1, `load_data`=0.
- **`LSU_MISALIGN_EXC_EN` undefined:** the `misalign` port is absent. Offending low address bits are ignored: a half uses `addr[1]`, a word uses lane 0. The access proceeds normally.

## Structure
- **Shared defines header** (alongside the ALU-op and immediate codes):
  - MemSize encodings `MEM_B`/`MEM_H`/`MEM_W`
  - FSM state codes `LSU_IDLE`/`LSU_REQ`/`LSU_RESP`/`LSU_DONE`
- **Sub-module `lsu_align`:** combinational byte-enable generation, store-lane replication, load extraction and extension. `lsu_ctrl` holds only the FSM and registers.

## Test plan
- **Store byte:** SB 0xA5 to 0x1003, immediate `mem_gnt` → `mem_addr` 0x1000, `mem_be` 1000, `mem_wdata` 0xA5A5A5A5, `mem_we`=1, `done` in cycle 2.
- **Load half, sign/zero:** LH at 0x2002 with `mem_rdata` 0x80011234 → `load_data` 0xFFFF8001. LHU with the same data → 0x00008001.
- **Delayed grant:** `mem_gnt` delayed 3 cycles → `mem_req`, address and enables stable, `stall`=1 throughout. `done` in the cycle after the gnt cycle's state transition.
- **Load word, back-to-back:** LW with `mem_rvalid` 2 cycles after gnt, data 0xDEADBEEF → `load_data` 0xDEADBEEF. A second SW is accepted in the cycle after DONE.
- **Misaligned word load:** LW at 0x3001. With the macro → no `mem_req`, and `done`=`misalign`=1 in cycle 1. Without the macro → `mem_addr` 0x3000, `mem_be` 1111.
- **Reset during RESP:** assert `rst` in RESP → all outputs 0, state IDLE, no `done`. A following `mem_rvalid` is ignored.
